// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC, picks the next PC each cycle
// (sequential, branch, jump/call, return, exception) and predicts return
// targets with a small circular return-address stack.
module pc_unit #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned       INSTR_BYTES  = 4,
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       stall_i,
    input  logic                       exc_i,
    input  logic                       branch_taken_i,
    input  logic [WIDTH-1:0]           branch_target_i,
    input  logic                       jump_i,
    input  logic                       call_i,
    input  logic [WIDTH-1:0]           jump_target_i,
    input  logic                       ret_i,
    input  logic [WIDTH-1:0]           ret_target_i,
    output logic [WIDTH-1:0]           pc_o,
    output logic                       pc_valid_o,
    output logic [$clog2(RAS_DEPTH):0] ras_count_o
);

    localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [WIDTH-1:0] PC_INC  = WIDTH'(INSTR_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             valid_reg, valid_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;     // next free slot; top is ptr_reg-1
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    logic             advance;
    logic             push;
    logic [WIDTH-1:0] seq_pc;
    logic [PTR_W-1:0] top_idx;
    logic [WIDTH-1:0] ras_top;

    // Exception overrides a stall, but nothing moves while the core is not started.
    assign advance = start_i & (~stall_i | exc_i);
    assign seq_pc  = pc_reg + PC_INC;
    assign top_idx = ptr_reg - PTR_W'(1);
    // The stack is a handful of flops, so the top is read combinationally
    // to keep the return redirect at one-cycle latency.
    assign ras_top = ras_mem[top_idx];

    // Next-PC selection by strict priority, plus the matching RAS pointer/count update.
    always_comb begin
        pc_next    = pc_reg;
        valid_next = advance;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        push       = 1'b0;
        if (advance) begin
            if (exc_i) begin
                pc_next    = EXC_VECTOR;
                ptr_next   = '0;
                count_next = '0;
            end else if (branch_taken_i) begin
                pc_next = branch_target_i;
            end else if (call_i) begin
                // A full stack overwrites its oldest entry; the pointer simply wraps.
                pc_next  = jump_target_i;
                push     = 1'b1;
                ptr_next = ptr_reg + PTR_W'(1);
                if (count_reg != CNT_MAX) begin
                    count_next = count_reg + CNT_W'(1);
                end
            end else if (jump_i) begin
                pc_next = jump_target_i;
            end else if (ret_i) begin
                if (count_reg != '0) begin
                    pc_next    = ras_top;
                    ptr_next   = top_idx;
                    count_next = count_reg - CNT_W'(1);
                end else begin
                    pc_next = ret_target_i;
                end
            end else begin
                pc_next = seq_pc;
            end
        end
    end

    // PC, valid flag and stack bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_reg    <= RESET_VECTOR;
            valid_reg <= 1'b0;
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
        end
    end

    // Return-address storage: write the link address into the free slot on a call.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem[i] <= '0;
            end
        end else if (push) begin
            ras_mem[ptr_reg] <= seq_pc;
        end
    end

    assign pc_o        = pc_reg;
    assign pc_valid_o  = valid_reg;
    assign ras_count_o = count_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0, stall_i = 1'b0, exc_i = 1'b0;
    logic        branch_taken_i = 1'b0, jump_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
    logic [31:0] branch_target_i = '0, jump_target_i = '0, ret_target_i = '0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic [2:0]  ras_count_o;

    pc_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .exc_i(exc_i), .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .call_i(call_i), .jump_target_i(jump_target_i),
        .ret_i(ret_i), .ret_target_i(ret_target_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .ras_count_o(ras_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: fetch PC, valid flag and the return stack as a queue
    // (newest at the back, oldest dropped from the front when it overflows).
    logic [31:0] m_pc = 32'h0;
    bit          m_valid = 1'b0;
    logic [31:0] m_ras[$];

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_pc    = 32'h0;
            m_valid = 1'b0;
            m_ras.delete();
        end else begin
            m_valid = start_i && (!stall_i || exc_i);
            if (m_valid) begin
                if (exc_i) begin
                    m_pc = 32'h80;
                    m_ras.delete();
                end else if (branch_taken_i) begin
                    m_pc = branch_target_i;
                end else if (call_i) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    m_pc = jump_target_i;
                end else if (jump_i) begin
                    m_pc = jump_target_i;
                end else if (ret_i) begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else m_pc = ret_target_i;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Literal expectations handed from the stimulus to the compare process.
    int          lit_req = 0;
    int          lit_ack = 0;
    string       lit_name = "";
    logic [31:0] lit_pc = '0;
    bit          lit_valid = 1'b0;
    int          lit_cnt = 0;
    bit          check_en = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    // Single compare process: DUT vs model every cycle, plus pending literal checks.
    always @(negedge clk_i) begin
        if (check_en) begin
            n_cmp++;
            if (pc_o !== m_pc) begin
                n_fail++;
                $display("FAIL pc t=%0t dut=%h model=%h", $time, pc_o, m_pc);
            end
            n_cmp++;
            if (pc_valid_o !== m_valid) begin
                n_fail++;
                $display("FAIL valid t=%0t dut=%b model=%b", $time, pc_valid_o, m_valid);
            end
            n_cmp++;
            if (int'(ras_count_o) != m_ras.size() || $isunknown(ras_count_o)) begin
                n_fail++;
                $display("FAIL count t=%0t dut=%0d model=%0d", $time, ras_count_o, m_ras.size());
            end
        end
        if (lit_ack != lit_req) begin
            lit_ack = lit_req;
            n_cmp++;
            if (pc_o !== lit_pc || m_pc !== lit_pc || pc_valid_o !== lit_valid || m_valid != lit_valid
                || int'(ras_count_o) != lit_cnt || m_ras.size() != lit_cnt) begin
                n_fail++;
                $display("FAIL %s: dut pc=%h v=%b cnt=%0d model pc=%h v=%b cnt=%0d want pc=%h v=%b cnt=%0d",
                         lit_name, pc_o, pc_valid_o, ras_count_o, m_pc, m_valid, m_ras.size(),
                         lit_pc, lit_valid, lit_cnt);
            end else begin
                $display("check %s: pc=%h v=%b cnt=%0d", lit_name, pc_o, pc_valid_o, ras_count_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] pc, input bit v, input int cnt);
        lit_name  = name;
        lit_pc    = pc;
        lit_valid = v;
        lit_cnt   = cnt;
        lit_req++;
    endtask

    task automatic set_in(input bit st, input bit sl, input bit ex, input bit br,
                          input logic [31:0] bt, input bit jp, input bit cl,
                          input logic [31:0] jt, input bit rt, input logic [31:0] rtt);
        start_i = st; stall_i = sl; exc_i = ex; branch_taken_i = br; branch_target_i = bt;
        jump_i = jp; call_i = cl; jump_target_i = jt; ret_i = rt; ret_target_i = rtt;
    endtask

    initial begin
        // Reset and sequential fetch
        rst_i = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        check_en = 1'b1;
        lit("reset", 32'h0, 1'b0, 0);
        rst_i = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); lit("seq_first", 32'h4, 1'b1, 0);
        tick(); tick(); lit("seq_12", 32'hC, 1'b1, 0);
        tick();
        // Stall and start gating
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick(); lit("stall_hold", 32'h10, 1'b0, 0);
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tick(); lit("start_low_exc", 32'h10, 1'b0, 0);
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick(); lit("exc_over_stall", 32'h80, 1'b1, 0);
        // Priority: branch beats call and jump, no push
        set_in(1, 0, 0, 0, 0, 1, 0, 32'h40, 0, 0);
        tick();
        set_in(1, 0, 0, 1, 32'h200, 1, 1, 32'h300, 0, 0);
        tick(); lit("priority", 32'h200, 1'b1, 0);
        // Call (with ret asserted too: push only) then return
        set_in(1, 0, 0, 0, 0, 1, 0, 32'h40, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 32'h100, 1, 32'hDEAD);
        tick(); lit("call", 32'h100, 1'b1, 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
        tick(); lit("ret", 32'h44, 1'b1, 0);
        // RAS overflow: five nested calls from 0x0..0x40
        set_in(1, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 1, 32'(i * 16), 0, 0);
            tick();
        end
        lit("ras_full", 32'h50, 1'b1, 4);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h900);
        tick(); lit("ret1", 32'h44, 1'b1, 3);
        tick(); tick();
        tick(); lit("ret4", 32'h14, 1'b1, 0);
        tick(); lit("ret_empty", 32'h900, 1'b1, 0);
        // Asynchronous reset between edges
        set_in(1, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0);
        tick(); lit("pre_reset", 32'h100, 1'b1, 2);
        rst_i = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lit("async_reset", 32'h0, 1'b0, 0);
        tick();
        rst_i = 1'b1;
        tick(); lit("resume", 32'h4, 1'b1, 0);
        // Wrap at the top of the address space
        set_in(1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); lit("wrap", 32'h0, 1'b1, 0);
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_i = ($urandom_range(299) != 0);
            set_in($urandom_range(9) != 0, $urandom_range(4) == 0, $urandom_range(24) == 0,
                   $urandom_range(7) == 0, $urandom & 32'hFFFF_FFFC,
                   $urandom_range(7) == 0, $urandom_range(4) == 0, $urandom & 32'hFFFF_FFFC,
                   $urandom_range(3) == 0, $urandom & 32'hFFFF_FFFC);
            tick();
        end
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined core; the next generation of the plain PC register.
- Holds the fetch PC and selects the next PC each cycle: sequential, branch, jump/call, return, or exception vector.
- Adds a configurable return-address stack (RAS) that predicts return targets.
- Sits at the head of IF; pc_o drives instruction memory and the IF/ID register.

Parameters:
WIDTH, 32, PC width in bits
RESET_VECTOR, 32'h0000_0000, value of pc_o after reset
EXC_VECTOR, 32'h0000_0080, target on exception
INSTR_BYTES, 4, sequential increment
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  core run enable; low holds PC
stall_i  input  1  hazard stall; holds PC
exc_i  input  1  exception redirect
branch_taken_i  input  1  resolved taken branch
branch_target_i  input  WIDTH  branch target
jump_i  input  1  unconditional jump
call_i  input  1  jump-and-link; target jump_target_i, pushes return address
jump_target_i  input  WIDTH  jump/call target
ret_i  input  1  return (jr $ra)
ret_target_i  input  WIDTH  architectural return address; used when RAS empty
pc_o  output  WIDTH  current fetch PC
pc_valid_o  output  1  fetch at pc_o is valid
ras_count_o  output  $clog2(RAS_DEPTH)+1  RAS occupancy

Behaviour:
- Reset (rst_i low, async): pc_o=RESET_VECTOR, pc_valid_o=0, ras_count_o=0, RAS pointer=0. Release mid-operation resumes from RESET_VECTOR.
- advance = start_i & (~stall_i | exc_i). exc_i overrides stall; start_i low blocks everything, including exc_i.
- pc_valid_o registered: next value = start_i & ~stall_i, or 1 when exc_i is taken.
- When advance=0: pc_o, RAS and count hold.
- When advance=1, next pc_o by strict priority:
  1. exc_i: EXC_VECTOR; RAS flushed (count=0).
  2. branch_taken_i: branch_target_i.
  3. call_i: jump_target_i; push pc_o+INSTR_BYTES.
  4. jump_i: jump_target_i.
  5. ret_i: if count>0, RAS top, then pop; else ret_target_i with no pop.
  6. otherwise: pc_o+INSTR_BYTES.
- Latency: one cycle; the selected target appears on pc_o the edge after the request.
- Arithmetic: pc_o+INSTR_BYTES wraps modulo 2^WIDTH. No alignment checks.
- Lower-priority requests in the same cycle are dropped with no RAS side effect. call_i+ret_i together means push only. call_i+jump_i means call.
- RAS is circular:
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no pointer change, fallback target used.
- ras_count_o is updated on the same edge as pc_o.

Test Plan:
- Reset/seq: rst_i low, then high with start_i=1 -> pc_o 0,4,8,12 on successive edges; pc_valid_o=1 from the first edge after start.
- Stall/start: stall_i=1 for 3 cycles at pc_o=0x10 -> pc_o holds 0x10, pc_valid_o=0. start_i=0 with exc_i=1 -> no change. stall_i=1 with exc_i=1 -> pc_o=0x80, ras_count_o=0.
- Priority: branch_taken_i=1 (0x200), jump_i=1 (0x300), call_i=1 at pc 0x40 together -> pc_o=0x200, ras_count_o unchanged.
- Call/return: call at 0x40 to 0x100, then ret_i with ret_target_i=0xDEAD -> pc_o=0x100, then 0x44; count 1 -> 0.
- RAS overflow: 5 nested calls from pcs 0x0,0x10,0x20,0x30,0x40 (RAS_DEPTH=4) -> count saturates at 4. Four rets yield 0x44,0x34,0x24,0x14. A fifth ret with ret_target_i=0x900 -> 0x900, count stays 0.
- Async reset mid-run: rst_i low between edges at pc_o=0x100 with RAS count 2 -> pc_o=0 and ras_count_o=0 immediately, without waiting for a clock edge.
